// File: rtl/waitstate_memory_if.sv
// Processor request/response bus plus word-serial preload port for waitstate_memory.
// The processor (or bench) uses the master modport; the memory uses the slave modport.
interface waitstate_memory_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = 32
) ();
   logic                     MemRead;
   logic                     MemWrite;
   logic [ADDR_W-1:0]        Address;
   logic [DATA_W-1:0]        WriteData;
   logic [DATA_W-1:0]        ReadData;
   logic                     Ready;
   logic                     Err;
   logic                     ld_valid;
   logic [$clog2(DEPTH)-1:0] ld_addr;
   logic [DATA_W-1:0]        ld_data;
   logic                     busy;

   modport master (
      output MemRead, MemWrite, Address, WriteData, ld_valid, ld_addr, ld_data,
      input  ReadData, Ready, Err, busy
   );

   modport slave (
      input  MemRead, MemWrite, Address, WriteData, ld_valid, ld_addr, ld_data,
      output ReadData, Ready, Err, busy
   );
endinterface

// File: rtl/waitstate_memory.sv
// Unified instruction/data memory with a programmable access latency and Ready handshake.
// Requests are latched on acceptance; the array access happens on the last wait-state edge.
module waitstate_memory #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 2048,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 2
) (
   input logic                clk,
   input logic                rst,
   waitstate_memory_if.slave  bus
);
   localparam int             IDX_W     = $clog2(DEPTH);
   localparam logic [3:0]     LAT_M1    = 4'(LATENCY - 1);
   localparam logic [IDX_W:0] DEPTH_EXT = (IDX_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          count_q, count_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                is_write_q, is_write_d;
   logic                both_q, both_d;
   logic [DATA_W-1:0]   read_data_q, read_data_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic                mem_we;
   logic [IDX_W-1:0]    mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   rd_word;

   logic [IDX_W-1:0]    idx;
   logic                hi_nz;
   logic                out_of_range;
   logic                misaligned;
   logic                addr_fault;

   // Fault decode works on the latched address so late Address changes are harmless.
   assign idx = addr_q[IDX_W+1:2];

   if (ADDR_W > IDX_W + 2) begin : g_hi
      assign hi_nz = |addr_q[ADDR_W-1:IDX_W+2];
   end else begin : g_no_hi
      assign hi_nz = 1'b0;
   end

   assign out_of_range = hi_nz || ({1'b0, idx} >= DEPTH_EXT);
   assign misaligned   = |addr_q[1:0];
   assign addr_fault   = out_of_range || misaligned;
   assign rd_word      = mem[idx];

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      is_write_d  = is_write_q;
      both_d      = both_q;
      read_data_d = read_data_q;
      ready_d     = 1'b0;
      err_d       = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = idx;
      mem_wdata   = wdata_q;

      case (state_q)
         S_IDLE: begin
            // Preload has priority; a pending request simply waits for ld_valid to drop.
            if (bus.ld_valid) begin
               mem_we    = 1'b1;
               mem_waddr = bus.ld_addr;
               mem_wdata = bus.ld_data;
            end else if (bus.MemRead || bus.MemWrite) begin
               addr_d     = bus.Address;
               wdata_d    = bus.WriteData;
               is_write_d = bus.MemWrite;
               both_d     = bus.MemRead && bus.MemWrite;
               count_d    = LAT_M1;
               state_d    = S_WAIT;
            end
         end

         S_WAIT: begin
            if (count_q == 4'd0) begin
               state_d = S_DONE;
               ready_d = 1'b1;
               err_d   = addr_fault || both_q;
               if (is_write_q) begin
                  mem_we = !addr_fault;
               end else begin
                  read_data_d = addr_fault ? '0 : rd_word;
               end
            end else begin
               count_d = count_q - 4'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         is_write_q  <= 1'b0;
         both_q      <= 1'b0;
         read_data_q <= '0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         is_write_q  <= is_write_d;
         both_q      <= both_d;
         read_data_q <= read_data_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
      end
   end

   // Array has no reset; the rst gate keeps an aborted access from committing.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.ReadData = read_data_q;
   assign bus.Ready    = ready_q;
   assign bus.Err      = err_q;
   assign bus.busy     = (state_q != S_IDLE);
endmodule
